// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-RAM program loader.
// Holds the FSM state encoding, the default frame marker and the word geometry.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DATA,
    ST_WRITE,
    ST_CHECK
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
  localparam int         WORD_W         = 24;
  localparam int         BYTES_PER_WORD = 3;

endpackage

// File: rtl/loader_word_assembler.sv
// Packs bytes MSB-first into a 24-bit word and keeps the running XOR of every byte shifted in.
// Latency: word_nxt/last are combinational on the current byte; no backpressure, shifts whenever shift_en is high.
module loader_word_assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [7:0]        byte_dat,
  output logic [WORD_W-1:0] word_nxt,
  output logic              last,
  output logic [7:0]        csum
);

  logic [WORD_W-1:0] sr_q;
  logic [1:0]        idx_q;

  // word_nxt already contains the byte being accepted, so the caller can latch a complete word on `last`
  assign word_nxt = {sr_q[WORD_W-9:0], byte_dat};
  assign last     = shift_en && (idx_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr_q  <= '0;
      idx_q <= '0;
      csum  <= '0;
    end else if (shift_en) begin
      sr_q  <= word_nxt;
      idx_q <= last ? 2'd0 : idx_q + 2'd1;
      csum  <= csum ^ byte_dat;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads framed bytes (SYNC, N, 3*(N+1) data bytes, XOR checksum) into the instruction RAM from address 0.
// Latency: ram_we one cycle after a word's third byte; backpressure: rx_ready drops only in the write cycle.
module program_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state_q, state_d;
  logic              xfer, asm_clr, asm_shift, asm_last;
  logic [WORD_W-1:0] asm_word;
  logic [7:0]        asm_csum;
  logic [ADDR_W-1:0] addr_q, n_q;

  assign rx_ready  = !rst && (state_q != ST_WRITE);
  assign busy      = (state_q != ST_IDLE);
  assign xfer      = rx_valid && rx_ready;
  assign asm_clr   = (state_q == ST_IDLE) && xfer && (rx_data == SYNC_BYTE);
  assign asm_shift = (state_q == ST_DATA) && xfer;

  loader_word_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .clr      (asm_clr),
    .shift_en (asm_shift),
    .byte_dat (rx_data),
    .word_nxt (asm_word),
    .last     (asm_last),
    .csum     (asm_csum)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (asm_clr) state_d = ST_COUNT;
      ST_COUNT: if (xfer) state_d = ST_DATA;
      ST_DATA:  if (asm_last) state_d = ST_WRITE;
      ST_WRITE: state_d = (addr_q == n_q) ? ST_CHECK : ST_DATA;
      ST_CHECK: if (xfer) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // addr_q doubles as the word counter; it may wrap after the last word of a full frame, but is never written there
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      n_q      <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q <= state_d;
      ram_we  <= asm_last;
      done    <= (state_q == ST_CHECK) && xfer;
      if (asm_clr) begin
        addr_q <= '0;
        err    <= 1'b0;
      end
      if ((state_q == ST_COUNT) && xfer) n_q <= ADDR_W'(rx_data);
      if (asm_last) begin
        ram_addr <= addr_q;
        ram_data <= asm_word;
      end
      if (state_q == ST_WRITE) addr_q <= addr_q + ADDR_W'(1);
      if ((state_q == ST_CHECK) && xfer) err <= (rx_data != asm_csum);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized frames against a list-level model of the loader: expected RAM writes and checksum status.
module tb_program_loader;
  import loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, ram_we, busy, done, err;
  logic [7:0]  ram_addr;
  logic [23:0] ram_data;

  program_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          rdy_viol = 0;
  logic        err_at_done = 1'b0;
  logic        busy_at_done = 1'b1;
  logic [31:0] wr_q[$];
  logic [7:0]  dat_q[$];

  // Observer: logs every RAM write and the status seen on each done pulse
  always @(negedge clk) begin
    if (ram_we) wr_q.push_back({ram_addr, ram_data});
    if (done) begin
      done_cnt++;
      err_at_done = err;
      busy_at_done = busy;
    end
    if (!rst && (rx_ready !== !ram_we)) rdy_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left just after a rising edge; a byte is taken on the first edge with rx_ready high
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int   gap;
    int   w;
    logic rdy;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_data = b;
    rx_valid = 1'b1;
    rdy = 1'b0;
    w = 0;
    while (!rdy && w < 16) begin
      @(negedge clk);
      rdy = rx_ready;
      @(posedge clk); #1;
      w++;
    end
    rx_valid = 1'b0;
    if (!rdy) chk("rx_ready wait", 32'(rx_ready), 32'd1);
  endtask

  // Sends a frame carrying dat_q and compares the DUT against the expected write list and status
  task automatic run_frame(input bit with_sync, input bit use_cs, input logic [7:0] cs_val,
                           input int gap, input string tag);
    int          nw;
    int          start;
    int          t;
    logic [7:0]  xr;
    logic [7:0]  cs;
    logic [23:0] w;
    nw = dat_q.size() / 3;
    xr = 8'h00;
    foreach (dat_q[i]) xr ^= dat_q[i];
    cs = use_cs ? cs_val : xr;
    wr_q.delete();
    start = done_cnt;
    if (with_sync) send_byte(8'hA5, gap);
    send_byte(8'(nw - 1), gap);
    foreach (dat_q[i]) send_byte(dat_q[i], gap);
    send_byte(cs, gap);
    t = 0;
    while (done_cnt == start && t < 20) begin @(posedge clk); t++; end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, " done pulses"}, 32'(done_cnt - start), 32'd1);
    chk({tag, " busy at done"}, 32'(busy_at_done), 32'd0);
    chk({tag, " err"}, 32'(err_at_done), 32'(cs != xr));
    chk({tag, " write count"}, 32'(wr_q.size()), 32'(nw));
    for (int k = 0; k < nw && k < wr_q.size(); k++) begin
      w = {dat_q[3*k], dat_q[3*k+1], dat_q[3*k+2]};
      chk($sformatf("%s write %0d", tag, k), wr_q[k], {k[7:0], w});
    end
  endtask

  initial begin
    logic [7:0] rcs;
    int         n;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rx_ready in reset", 32'(rx_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("flags after reset", 32'({rx_ready, ram_we, busy, done, err}), 32'b10000);
    chk("ram_addr after reset", 32'(ram_addr), 32'd0);
    chk("ram_data after reset", 32'(ram_data), 32'd0);
    @(posedge clk); #1;

    dat_q = '{8'h12, 8'h34, 8'h56};
    run_frame(1'b1, 1'b0, 8'h00, 0, "single");

    dat_q = '{8'h12, 8'h34, 8'h56};
    run_frame(1'b1, 1'b1, 8'h00, 0, "badcs");
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("err sticky", 32'(err), 32'd1);
    @(posedge clk); #1;
    send_byte(8'hA5, 0);
    @(negedge clk);
    chk("err cleared by sync", 32'(err), 32'd0);
    @(posedge clk); #1;
    dat_q = '{8'h01, 8'h02, 8'h03};
    run_frame(1'b0, 1'b0, 8'h00, 0, "after sync");

    dat_q = '{8'hA5, 8'hA5, 8'hA5};
    run_frame(1'b1, 1'b0, 8'h00, 0, "a5 data");

    // Same payload gap-free, then behind noise bytes with random valid gaps
    dat_q.delete();
    for (int i = 0; i < 9; i++) dat_q.push_back(8'($urandom_range(0, 255)));
    run_frame(1'b1, 1'b0, 8'h00, 0, "nogap");
    send_byte(8'h00, 2);
    send_byte(8'hFF, 2);
    send_byte(8'h3C, 2);
    @(negedge clk);
    chk("noise ignored", 32'(busy), 32'd0);
    @(posedge clk); #1;
    run_frame(1'b1, 1'b0, 8'h00, 3, "gaps");

    for (int f = 0; f < 4; f++) begin
      n = int'($urandom_range(1, 6));
      dat_q.delete();
      for (int i = 0; i < 3 * n; i++) dat_q.push_back(8'($urandom_range(0, 255)));
      rcs = 8'($urandom_range(0, 255));
      run_frame(1'b1, ($urandom_range(0, 2) == 0), rcs, f % 3, $sformatf("rand%0d", f));
    end

    dat_q.delete();
    for (int k = 0; k < 256; k++) begin
      dat_q.push_back(8'(k));
      dat_q.push_back(~8'(k));
      dat_q.push_back(8'hA5);
    end
    run_frame(1'b1, 1'b0, 8'h00, 0, "full");
    chk("full addr hold", 32'(ram_addr), 32'hFF);

    // Reset after 4 data bytes of a two-word frame
    wr_q.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rx_ready mid reset", 32'(rx_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("flags after mid reset", 32'({busy, ram_we, err}), 32'd0);
    chk("writes before reset", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() > 0) chk("write before reset", wr_q[0], 32'h00112233);
    @(posedge clk); #1;
    dat_q = '{8'hAA, 8'hBB, 8'hCC};
    run_frame(1'b1, 1'b0, 8'h00, 1, "post reset");

    chk("rx_ready low only in write", 32'(rdy_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
